// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and small op-decoding helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on
// an unsigned {hi, lo} accumulator pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Multiply adds the multiplicand when the low bit is set and shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    w_shift = {i_hi, i_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_opnd};
    if (i_div) begin
      if (w_shift >= {1'b0, i_opnd}) begin
        o_hi = w_diff[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_shift[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: WIDTH radix-2
// steps on operand magnitudes, then one sign-fix cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_div, r_neg_q, r_neg_r, r_bz;
  logic             r_busy, r_done, r_dz;
  logic [WIDTH-1:0] r_a, r_acc_hi, r_acc_lo, r_opnd;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] w_step_hi, w_step_lo, w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_fix_hi, w_fix_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_accept, w_sa, w_sb;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sa     = op_is_signed(op) & a[WIDTH-1];
  assign w_sb     = op_is_signed(op) & b[WIDTH-1];
  assign w_a_mag  = w_sa ? -a : a;
  assign w_b_mag  = w_sb ? -b : b;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_hi   (r_acc_hi),
    .i_lo   (r_acc_lo),
    .i_opnd (r_opnd),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
               else          w_state_nxt = ST_IDLE;
      ST_CALC: if (r_cnt == CNT_ONE) w_state_nxt = ST_FIX;
               else                  w_state_nxt = ST_CALC;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: if (w_accept) w_state_nxt = ST_CALC;
               else          w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign correction and divide-by-zero override applied in FIX
  always_comb begin
    w_prod   = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_bz) begin
        w_fix_hi = r_a;
        w_fix_lo = {WIDTH{1'b1}};
      end else begin
        w_fix_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
        w_fix_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
      end
    end else begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
      r_a      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
    end else if (w_accept) begin
      r_cnt    <= CNT_INIT;
      r_div    <= op_is_div(op);
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_bz     <= (b == {WIDTH{1'b0}});
      r_a      <= a;
      r_acc_hi <= '0;
      r_acc_lo <= w_a_mag;
      r_opnd   <= w_b_mag;
    end else if (r_state == ST_CALC) begin
      r_cnt    <= r_cnt - CNT_ONE;
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
    end
  end

  // HI/LO result registers: FIX result, or direct writes while not busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if (!r_busy) begin
      if (hi_we) r_hi <= wd;
      if (lo_we) r_lo <= wd;
    end
  end

  // Registered status flags decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_FIX);
      r_done <= (w_state_nxt == ST_DONE);
      r_dz   <= (r_state == ST_FIX) && r_div && r_bz;
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32: table of operations plus
// hand-written sequences for ignored start, direct writes, back-to-back and reset abort.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0, b = 32'h0, wd = 32'h0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, dz;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a start for one edge; returns #1 after the sampling edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle count from the sampling edge (1) to the edge after which done is high.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  initial begin
    int  cyc;
    bit  bok;
    int  ndone;
    int  done_cyc;
    logic [31:0] hold_hi, done_hi, done_lo;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{2'b01, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_dz", {31'b0, dz}, 32'h0);

    // Table-driven operations
    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc, bok);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd34);
      chk($sformatf("v%0d_busy_run", i), {31'b0, bok}, 32'h1);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_dz", i), {31'b0, dz}, {31'b0, vecs[i].dz});
      chk($sformatf("v%0d_busy_done", i), {31'b0, busy}, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
      chk($sformatf("v%0d_dz_clear", i), {31'b0, dz}, 32'h0);
      chk($sformatf("v%0d_hi_hold", i), hi, vecs[i].hi);
    end

    // Start and hi_we during CALC are ignored
    hold_hi = hi;
    launch(2'b10, 32'd10, 32'd3);
    cyc = 1;
    repeat (5) begin @(posedge clk); cyc++; end
    #1;
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd7; hi_we = 1'b1; wd = 32'h55;
    @(posedge clk);
    cyc++;
    #1;
    start = 1'b0; hi_we = 1'b0;
    chk("calc_hi_we_ignored", hi, hold_hi);
    ndone = 0; done_cyc = 0; done_hi = 32'h0; done_lo = 32'h0;
    repeat (50) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        done_hi = hi;
        done_lo = lo;
      end
    end
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_latency", 32'(done_cyc), 32'd34);
    chk("ign_hi", done_hi, 32'h1);
    chk("ign_lo", done_lo, 32'h3);

    // Direct write accepted alongside a start; result still from latched operands
    @(negedge clk);
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1; hi_we = 1'b1; wd = 32'hABCD;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    chk("start_hi_we", hi, 32'hABCD);
    wait_done(cyc, bok);
    chk("start_we_latency", 32'(cyc), 32'd34);
    chk("start_we_hi", hi, 32'h0);
    chk("start_we_lo", lo, 32'h6);

    // Start accepted in DONE goes straight back to CALC
    #0;
    start = 1'b1; op = 2'b10; a = 32'd20; b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'h1);
    wait_done(cyc, bok);
    chk("b2b_latency", 32'(cyc), 32'd34);
    chk("b2b_hi", hi, 32'h2);
    chk("b2b_lo", lo, 32'h3);

    // Direct write to LO while idle
    @(posedge clk);
    @(negedge clk);
    lo_we = 1'b1; wd = 32'h1234;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    chk("idle_lo_we", lo, 32'h1234);
    chk("idle_hi_keep", hi, 32'h2);

    // Reset mid-operation aborts without a done pulse
    launch(2'b00, 32'hFFFFFFFF, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Unit is usable again after the abort
    launch(vecs[0].op, vecs[0].a, vecs[0].b);
    wait_done(cyc, bok);
    chk("post_latency", 32'(cyc), 32'd34);
    chk("post_hi", hi, vecs[0].hi);
    chk("post_lo", lo, vecs[0].lo);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request operation; sampled on clk rise.
REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (dividend a, divisor b).
REQ-007 SHALL have ports hi_we, lo_we  input  1  direct write of HI/LO (mthi/mtlo).
REQ-008 SHALL have port wd  input  WIDTH  direct-write data.
REQ-009 SHALL have ports hi, lo  output  WIDTH  result registers.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; HI/LO hold new result.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, valid while done=1.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in CALC/FIX ignored, no state change.
REQ-015 On accepted start SHALL latch op, a, b; enter CALC next cycle.
REQ-016 CALC SHALL last exactly WIDTH cycles, one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes).
REQ-017 FIX SHALL last 1 cycle: apply sign correction for MULT/DIV; write HI/LO at its end.
REQ-018 DONE SHALL last 1 cycle, then IDLE unless a new start is accepted (-> CALC).
REQ-019 Latency: start sampled at edge N -> done=1 in cycle after edge N+WIDTH+1; WIDTH+2 cycles start-to-done.
REQ-020 busy SHALL be 1 exactly in CALC and FIX; done 1 exactly in DONE.
REQ-021 MULTU/MULT: {hi,lo} = full 2*WIDTH-bit product, unsigned/two's-complement.
REQ-022 DIVU/DIV: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-023 DIV of most-negative by -1: lo = most-negative, hi = 0, no flag.
REQ-024 Divide with b=0: hi = a, lo = all ones, dz=1 in DONE; same latency.
REQ-025 dz SHALL be 0 for all multiplies and non-zero divides.
REQ-026 hi_we/lo_we SHALL update HI/LO from wd next edge only when busy=0; ignored while busy.
REQ-027 hi_we/lo_we in same cycle as accepted start: write takes effect; operation proceeds from latched operands.
REQ-028 HI/LO SHALL hold value except on FIX completion, direct write, or reset.

Reset
REQ-029 reset SHALL force IDLE, hi=0, lo=0, busy=0, done=0, dz=0 asynchronously.
REQ-030 reset mid-operation SHALL abort it; no done pulse follows.

Structure
REQ-031 Op encodings and FSM state encoding SHALL live in shared package mdu_pkg.
REQ-032 Per-cycle add/subtract-and-shift datapath SHALL be sub-module mdu_step, parametrised by WIDTH.
REQ-033 Counter SHALL be $clog2(WIDTH)+1 bits; no combinational WIDTHxWIDTH multiplier or divider.

Verification (WIDTH=32)
REQ-034 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, dz=0.
REQ-035 MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-037 DIVU a=100 b=0 -> hi=0x00000064, lo=0xFFFFFFFF, dz=1 for one cycle.
REQ-038 Start DIVU 10/3, re-assert start and hi_we (wd=0x55) during CALC -> ignored; done once, hi=1, lo=3.
REQ-039 Start MULTU, assert reset 10 cycles later -> busy=0, hi=lo=0 immediately; no done within 40 cycles.
